// File: rtl/ram512_arbiter.sv
// Round-robin arbiter sharing one RAM512 between two clients, with registered read return.
// Optional power-up zero sweep of the RAM when CLEAR_ON_RESET_EN is defined.
module ram512_arbiter #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AWIDTH = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [WIDTH-1:0]  wdata0,
  input  logic [WIDTH-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [WIDTH-1:0]  rdata0,
  output logic [WIDTH-1:0]  rdata1,
  output logic              busy,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load,
  output logic [AWIDTH-1:0] ram_address,
  input  logic [WIDTH-1:0]  ram_out
);

`ifdef CLEAR_ON_RESET_EN
  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_CLEAR = 1'b1} state_t;
  localparam state_t RESET_STATE = ST_CLEAR;
`else
  typedef enum logic [0:0] {ST_ARB = 1'b0} state_t;
  localparam state_t RESET_STATE = ST_ARB;
`endif

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ptr;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [WIDTH-1:0]    r_rdata0;
  logic [WIDTH-1:0]    r_rdata1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_busy;
  logic [WIDTH-1:0]    w_ram_in;
  logic                w_ram_load;
  logic [AWIDTH-1:0]   w_ram_address;
`ifdef CLEAR_ON_RESET_EN
  logic [AWIDTH-1:0]   r_clr_cnt;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RESET_STATE;
    else          r_state <= w_state_nxt;
  end

  // Next state, grant decision and RAM port mux; everything is forced idle while in reset
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt0        = 1'b0;
    w_gnt1        = 1'b0;
    w_busy        = 1'b0;
    w_ram_in      = '0;
    w_ram_load    = 1'b0;
    w_ram_address = '0;
`ifdef CLEAR_ON_RESET_EN
    w_busy = (r_state == ST_CLEAR);
`endif
    if (reset_n) begin
      case (r_state)
        ST_ARB: begin
          if (req0 && (!req1 || !r_ptr)) w_gnt0 = 1'b1;
          else if (req1)                 w_gnt1 = 1'b1;
          if (w_gnt0) begin
            w_ram_address = addr0;
            w_ram_in      = wdata0;
            w_ram_load    = we0;
          end else if (w_gnt1) begin
            w_ram_address = addr1;
            w_ram_in      = wdata1;
            w_ram_load    = we1;
          end
        end
`ifdef CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          w_ram_address = r_clr_cnt;
          w_ram_load    = 1'b1;
          if (&r_clr_cnt) w_state_nxt = ST_ARB;
        end
`endif
        default: w_state_nxt = ST_ARB;
      endcase
    end
  end

`ifdef CLEAR_ON_RESET_EN
  // Sweep address; wraps back to zero on the last clear write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR)  r_clr_cnt <= r_clr_cnt + AWIDTH'(1);
  end
`endif

  // Pointer names the client that wins the next tie: always the one not just served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_ptr <= 1'b0;
    else if (w_gnt0) r_ptr <= 1'b1;
    else if (w_gnt1) r_ptr <= 1'b0;
  end

  // Read return path, one register stage per client
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_gnt0 && !we0;
      r_rvalid1 <= w_gnt1 && !we1;
      if (w_gnt0 && !we0) r_rdata0 <= ram_out;
      if (w_gnt1 && !we1) r_rdata1 <= ram_out;
    end
  end

  assign gnt0        = w_gnt0;
  assign gnt1        = w_gnt1;
  assign busy        = w_busy;
  assign ram_in      = w_ram_in;
  assign ram_load    = w_ram_load;
  assign ram_address = w_ram_address;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Bench for ram512_arbiter: behavioural RAM512, two client drivers, read-data scoreboard.
module tb_ram512_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [8:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_load;
  logic [15:0] rdata0, rdata1, ram_in, ram_out;
  logic [8:0]  ram_address;

  logic [15:0] mem [512];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          gnt_log[$];
  logic        exp_rv0 = 1'b0, exp_rv1 = 1'b0;
  int          n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  ram512_arbiter #(.WIDTH(16), .AWIDTH(9)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  // RAM512: synchronous write, combinational read
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output monitor: rvalid timing from observed accepts, rdata against the scoreboard
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
    end else begin
      if (gnt0 || gnt1) check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
      if (rvalid0 || exp_rv0) check("rvalid0", 32'(rvalid0), 32'(exp_rv0));
      if (rvalid1 || exp_rv1) check("rvalid1", 32'(rvalid1), 32'(exp_rv1));
      if (rvalid0 && exp_rv0) begin
        if (q0.size() == 0) check("q0_underflow", 32'd1, 32'd0);
        else check("rdata0", 32'(rdata0), 32'(q0.pop_front()));
      end
      if (rvalid1 && exp_rv1) begin
        if (q1.size() == 0) check("q1_underflow", 32'd1, 32'd0);
        else check("rdata1", 32'(rdata1), 32'(q1.pop_front()));
      end
      exp_rv0 = req0 && gnt0 && !we0;
      exp_rv1 = req1 && gnt1 && !we1;
      if (gnt0) gnt_log.push_back(0);
      if (gnt1) gnt_log.push_back(1);
    end
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    check("rst_rdata0", 32'(rdata0), 32'd0);
    check("rst_rdata1", 32'(rdata1), 32'd0);
    check("rst_ram_load", 32'(ram_load), 32'd0);
    check("rst_ram_addr", 32'(ram_address), 32'd0);
    check("rst_ram_in", 32'(ram_in), 32'd0);
`ifdef CLEAR_ON_RESET_EN
    check("rst_busy", 32'(busy), 32'd1);
`else
    check("rst_busy", 32'(busy), 32'd0);
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One access by client c; holds the request until granted, then releases after the edge
  task automatic do_op(input int c, input logic we, input logic [8:0] a,
                       input logic [15:0] d, input logic [15:0] exp_rd);
    bit got = 1'b0;
    if (c == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d;
      if (!we) q0.push_back(exp_rd);
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d;
      if (!we) q1.push_back(exp_rd);
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ((c == 0) ? gnt0 : gnt1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (c == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic check_log(input string tag, input int exp0, input int exp1);
    if (gnt_log.size() < 2) check({tag, "_len"}, 32'(gnt_log.size()), 32'd2);
    else begin
      check({tag, "_g0"}, 32'(gnt_log[0]), 32'(exp0));
      check({tag, "_g1"}, 32'(gnt_log[1]), 32'(exp1));
    end
  endtask

  task automatic wait_drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int nb;
    bit seen;
    apply_reset();
`ifdef CLEAR_ON_RESET_EN
    repeat (520) @(posedge clk);
    #1;
`endif
    // Write then read back-to-back from client 0
    gnt_log.delete();
    do_op(0, 1'b1, 9'h005, 16'h1234, 16'h0);
    do_op(0, 1'b0, 9'h005, 16'h0, 16'h1234);
    wait_drain();
    check_log("wr_rd", 0, 0);

    // Preload, leaving the pointer at client 0, then contend continuously
    do_op(0, 1'b1, 9'h010, 16'hAAAA, 16'h0);
    do_op(1, 1'b1, 9'h1FF, 16'h5555, 16'h0);
    gnt_log.delete();
    fork
      begin
        do_op(0, 1'b0, 9'h010, 16'h0, 16'hAAAA);
        do_op(0, 1'b0, 9'h010, 16'h0, 16'hAAAA);
      end
      begin
        do_op(1, 1'b0, 9'h1FF, 16'h0, 16'h5555);
        do_op(1, 1'b0, 9'h1FF, 16'h0, 16'h5555);
      end
    join
    wait_drain();
    check("fair_len", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) begin
      check("fair_g2", 32'(gnt_log[2]), 32'd0);
      check("fair_g3", 32'(gnt_log[3]), 32'd1);
    end
    check_log("fair", 0, 1);

    // Back-to-back writes by client 1, back-to-back reads by client 0
    for (int i = 0; i < 3; i++) do_op(1, 1'b1, 9'(9'h040 + i), 16'(i + 1), 16'h0);
    for (int i = 0; i < 3; i++) do_op(0, 1'b0, 9'(9'h040 + i), 16'h0, 16'(i + 1));
    wait_drain();

    // Return pointer to client 0, then same-address write/read collision
    do_op(1, 1'b0, 9'h040, 16'h0, 16'h0001);
    wait_drain();
    gnt_log.delete();
    fork
      do_op(0, 1'b1, 9'h100, 16'hBEEF, 16'h0);
      do_op(1, 1'b0, 9'h100, 16'h0, 16'hBEEF);
    join
    wait_drain();
    check_log("collide", 0, 1);

    // Reset lands in the cycle a read is granted
    req0 = 1'b1; we0 = 1'b0; addr0 = 9'h005;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt0) begin
        seen = 1'b1;
        break;
      end
    end
    check("midrst_grant", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_gnt0", 32'(gnt0), 32'd0);
    @(posedge clk);
    #1;
    req0 = 1'b0;
    check("midrst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    check("midrst_rdata0", 32'(rdata0), 32'd0);
    check("midrst_rdata1", 32'(rdata1), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    gnt_log.delete();
    fork
      do_op(1, 1'b1, 9'h020, 16'h1111, 16'h0);
      do_op(0, 1'b1, 9'h021, 16'h2222, 16'h0);
    join
    wait_drain();
    check_log("post_rst_tie", 0, 1);

`ifdef CLEAR_ON_RESET_EN
    // Power-up sweep clears preloaded words and blocks grants for 512 cycles
    do_op(0, 1'b1, 9'h000, 16'hFFFF, 16'h0);
    do_op(1, 1'b1, 9'h1FF, 16'hFFFF, 16'h0);
    wait_drain();
    apply_reset();
    nb = 0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clk);
          if (!busy) break;
          nb++;
          check("clear_no_gnt", 32'(gnt0 | gnt1), 32'd0);
        end
        check("clear_first_gnt", 32'(gnt0), 32'd1);
      end
      do_op(0, 1'b0, 9'h000, 16'h0, 16'h0000);
    join
    check("busy_cycles", 32'(nb), 32'd512);
    do_op(1, 1'b0, 9'h1FF, 16'h0, 16'h0000);
    wait_drain();
`else
    nb = 0;
    check("busy_tied_low", 32'(busy), 32'(nb));
`endif

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram512_arbiter.md
Name: ram512_arbiter

Overview:
- Two-requester arbiter that shares one RAM512 instance (16-bit words, 9-bit address) between two clients.
- Round-robin grant, one access per cycle, and registered read data returned one cycle after grant.
- Sits between the RAM512 and the two bus masters; it is the only block that drives RAM512's in, load and address.

Parameters:
- WIDTH, 16, data word width; must match RAM512.
- AWIDTH, 9, address width; must match RAM512.

Ports:
- clk  in  1  rising-edge clock shared with RAM512
- reset_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request from client 0 / 1
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  AWIDTH  word address from client 0 / 1
- wdata0 / wdata1  in  WIDTH  write data from client 0 / 1
- gnt0 / gnt1  out  1  combinational grant; access is accepted in any cycle where req and gnt are both high
- rvalid0 / rvalid1  out  1  read data valid, one cycle after an accepted read
- rdata0 / rdata1  out  WIDTH  registered read data; holds its value until the next read for that client
- busy  out  1  high while the arbiter cannot grant (clear sweep only)
- ram_in  out  WIDTH  to RAM512 in
- ram_load  out  1  to RAM512 load
- ram_address  out  AWIDTH  to RAM512 address
- ram_out  in  WIDTH  from RAM512 out; combinational read of ram_address

Behaviour:
- Reset (reset_n low, asynchronous):
  - gnt*, rvalid*, ram_load = 0; rdata* = 0; ram_address = 0; ram_in = 0.
  - Priority pointer = client 0 (client 0 wins the first tie).
  - busy = 0, or 1 when CLEAR_ON_RESET_EN is defined.
- States: CLEAR (present only with the macro) and ARB.
- ARB grant rules, one grant per cycle:
  - Only one client requesting: that client is granted.
  - Both requesting: the client named by the pointer is granted. After a tie the pointer flips to the loser.
  - After a sole-requester grant the pointer points to the other client.
  - Nothing requested: no grant; the pointer holds.
- Mux in the accepted cycle: ram_address = granted addr, ram_in = granted wdata, ram_load = granted we.
  - Idle cycle: ram_load = 0, ram_address = 0, ram_in = 0.
- Write: the RAM captures on the same rising edge that ends the accept cycle. No response is returned.
- Read: ram_out is sampled at the end of the accept cycle into rdata of the granted client.
  - rvalid for that client is high for exactly the following cycle.
  - The other client's rdata and rvalid are unaffected.
- Back-to-back:
  - A client may be granted on consecutive cycles; rvalid may stay high continuously.
  - A read to an address granted in the cycle after a write to the same address returns the new data.
  - A read and a write to the same address cannot share a cycle; they serialize in grant order.
- Fairness: under continuous requests from both clients, grants alternate 0,1,0,1 starting with 0 after reset.
- The request side holds req, we, addr and wdata stable until granted. The arbiter does not check this.
- Mid-operation reset: an in-flight read's rvalid is dropped. A write whose accepting edge has not occurred is not performed.

Optional Feature:
- Macro: CLEAR_ON_RESET_EN.
- Defined:
  - After reset_n deasserts, the FSM enters CLEAR. A 9-bit counter drives ram_address = 0..511, ram_in = 0, ram_load = 1, for 512 cycles.
  - busy = 1 and gnt* = 0 throughout CLEAR. Requests are ignored and stay pending.
  - After the write to address 511 the FSM moves to ARB and busy falls. The first grant can occur in the cycle busy is low.
  - Reset during CLEAR restarts the sweep at address 0.
- Undefined: no CLEAR state and no counter; busy is tied 0; the FSM starts in ARB; RAM contents are left as-is.

Test Plan:
- Reset then client 0 writes 0x1234 at 0x005; next cycle it reads 0x005 -> gnt0 high both cycles; rvalid0 high in cycle 3; rdata0 = 0x1234; rvalid1 stays 0.
- Both clients request continuously; client 0 reads 0x010 (holding 0xAAAA), client 1 reads 0x1FF (holding 0x5555) -> grants 0,1,0,1; rdata0 = 0xAAAA, rdata1 = 0x5555 each one cycle after the matching grant.
- Client 1 alone issues 3 back-to-back writes to 0x040–0x042 (0x0001–0x0003), then client 0 reads them -> 0x0001, 0x0002, 0x0003 with rvalid0 high for 3 consecutive cycles.
- Same cycle: client 0 writes 0xBEEF at 0x100 and client 1 reads 0x100, pointer = 0 -> write is granted first; the read is granted the next cycle and returns 0xBEEF.
- Assert reset_n low in the cycle a read is granted -> rvalid* = 0, rdata* = 0 after reset, pointer back to client 0.
- With CLEAR_ON_RESET_EN: preload 0xFFFF at 0x000 and 0x1FF, then reset -> busy high for exactly 512 cycles with no grants; afterwards reads of 0x000 and 0x1FF return 0x0000.
